// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed 32-bit multiplier / divider.
//   Multiply: radix-4 modified Booth, 16 steps, result = product[31:0].
//   Divide:   non-restoring on magnitudes, 32 steps, quotient truncated toward zero.
// A start pulse in any state restarts the unit with the new operands; an
// aborted operation never raises data_resultRDY.
// Optional feature macro: MULTDIV_EARLY_DIV0_EN -- when defined, a divide
// by zero finishes one edge after the start instead of running 32 steps.
module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

`ifdef MULTDIV_EARLY_DIV0_EN
    localparam logic EARLY_DIV0 = 1'b1;
`else
    localparam logic EARLY_DIV0 = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;

    // multiply datapath: accumulator, multiplicand shifted 2 bits per step,
    // multiplier shifted right 2 bits per step with the previous bit kept aside
    logic [63:0] acc;
    logic [63:0] mc_sh;
    logic [31:0] mpl;
    logic        mprev;

    // divide datapath: signed partial remainder, quotient/dividend shift register
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        q_neg;
    logic        div0;
    logic        ovf;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [2:0]  win;
    logic [63:0] pp;
    logic [63:0] acc_n;
    logic        mul_exc;
    logic [32:0] rem_sh;
    logic [32:0] rem_n;
    logic [31:0] quo_n;
    logic [31:0] quot;

    // operand magnitudes (0x80000000 maps onto itself, which is correct unsigned)
    assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    // Booth digit selection and accumulation for the current step
    always_comb begin
        win = {mpl[1:0], mprev};
        case (win)
            3'b001, 3'b010: pp = mc_sh;
            3'b011:         pp = mc_sh << 1;
            3'b100:         pp = -(mc_sh << 1);
            3'b101, 3'b110: pp = -mc_sh;
            default:        pp = '0;
        endcase
        acc_n   = acc + pp;
        mul_exc = !((&acc_n[63:31]) || (~|acc_n[63:31]));
    end

    // non-restoring step; the quotient bits produced this way need no
    // correction, only the (unused) remainder would, so the sign fix is all
    // that is applied on the last step
    always_comb begin
        rem_sh = {rem[31:0], quo[31]};
        rem_n  = rem[32] ? (rem_sh + {1'b0, dvsr}) : (rem_sh - {1'b0, dvsr});
        quo_n  = {quo[30:0], ~rem_n[32]};
        quot   = q_neg ? -quo_n : quo_n;
    end

    // control FSM, iteration counter, datapath registers and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            mc_sh          <= '0;
            mpl            <= '0;
            mprev          <= 1'b0;
            rem            <= '0;
            quo            <= '0;
            dvsr           <= '0;
            q_neg          <= 1'b0;
            div0           <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                cnt   <= '0;
                acc   <= '0;
                mc_sh <= {{32{data_operandA[31]}}, data_operandA};
                mpl   <= data_operandB;
                mprev <= 1'b0;
                rem   <= '0;
                quo   <= abs_a;
                dvsr  <= abs_b;
                q_neg <= data_operandA[31] ^ data_operandB[31];
                div0  <= (data_operandB == 32'h0);
                ovf   <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
                state <= ctrl_MULT ? MUL : DIV;
            end else begin
                case (state)
                    MUL: begin
                        acc   <= acc_n;
                        mc_sh <= mc_sh << 2;
                        mpl   <= {{2{mpl[31]}}, mpl[31:2]};
                        mprev <= mpl[1];
                        cnt   <= cnt + 6'd1;
                        if (cnt == 6'd15) begin
                            data_result    <= acc_n[31:0];
                            data_exception <= mul_exc;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end
                    end
                    DIV: begin
                        if (EARLY_DIV0 && div0) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end else begin
                            rem <= rem_n;
                            quo <= quo_n;
                            cnt <= cnt + 6'd1;
                            if (cnt == 6'd31) begin
                                data_result    <= div0 ? 32'h0 : quot;
                                data_exception <= div0 | ovf;
                                data_resultRDY <= 1'b1;
                                state          <= DONE;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
